// File: rtl/control_movimiento_param_if.sv
// rtl/control_movimiento_param_if.sv - sensor/position inputs and motor command outputs of the tracker
// Signals:
//   s                          mode select (1 = manual, 0 = automatic)
//   R_vertical_1/2             photoresistor pair, teta axis
//   R_horizontal_1/2           photoresistor pair, fi axis
//   teta_manual, fi_manual     manual target positions
//   teta_actual, fi_actual     current positions
//   s_out_teta, s_out_fi       motor command (00 stop, 01 cw, 11 ccw)
//   falla_teta, falla_fi       timeout fault flags
// Modports: slave = controller, master = front end / driver side.
interface control_movimiento_param_if #(
    parameter int W = 16
);
    logic         s;
    logic [W-1:0] R_vertical_1;
    logic [W-1:0] R_vertical_2;
    logic [W-1:0] R_horizontal_1;
    logic [W-1:0] R_horizontal_2;
    logic [W-1:0] teta_manual;
    logic [W-1:0] fi_manual;
    logic [W-1:0] teta_actual;
    logic [W-1:0] fi_actual;
    logic [1:0]   s_out_teta;
    logic [1:0]   s_out_fi;
    logic         falla_teta;
    logic         falla_fi;

    modport slave (
        input  s, R_vertical_1, R_vertical_2, R_horizontal_1, R_horizontal_2,
               teta_manual, fi_manual, teta_actual, fi_actual,
        output s_out_teta, s_out_fi, falla_teta, falla_fi
    );

    modport master (
        output s, R_vertical_1, R_vertical_2, R_horizontal_1, R_horizontal_2,
               teta_manual, fi_manual, teta_actual, fi_actual,
        input  s_out_teta, s_out_fi, falla_teta, falla_fi
    );
endinterface

// File: rtl/control_movimiento_param.sv
// rtl/control_movimiento_param.sv - two-axis solar tracker motion controller with deadband, dwell and timeout
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   control_movimiento_param_if.slave (sensor/position inputs, motor commands, fault flags)
// Each axis (0 = teta, 1 = fi) runs its own IDLE/MOVE_CW/MOVE_CCW/DWELL/FAULT machine;
// the registered mode bit is shared so a mode toggle hits both axes on the same edge.
// Optional feature macro: POS_LIMIT_EN (travel limits POS_MIN/POS_MAX block and end moves).
module control_movimiento_param #(
    parameter int           W         = 16,
    parameter int           DEADBAND  = 8,
    parameter int           HYST      = 2,
    parameter int           DWELL_CYC = 1000,
    parameter int           MAX_MOVE  = 1000000,
    parameter logic [W-1:0] POS_MIN   = '0,
    parameter logic [W-1:0] POS_MAX   = '1
) (
    input logic                          clk,
    input logic                          rst,
    control_movimiento_param_if.slave    bus
);
    localparam int CNT_TOP = (DWELL_CYC > MAX_MOVE) ? DWELL_CYC : MAX_MOVE;
    localparam int CW      = $clog2(CNT_TOP);

    localparam logic [W-1:0]  DB_W        = W'(DEADBAND);
    localparam logic [W-1:0]  HYST_W      = W'(HYST);
    localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] MOVE_LAST   = CW'(MAX_MOVE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CW,
        ST_CCW,
        ST_DWELL,
        ST_FAULT
    } state_t;

    // Reset loads s_q from s as well, so reset itself never looks like a toggle.
    logic s_q;
    logic toggle;

    always_ff @(posedge clk) begin
        s_q <= bus.s;
    end

    assign toggle = (bus.s != s_q);

    for (genvar g = 0; g < 2; g++) begin : g_axis
        logic [W-1:0]    r1, r2, tgt, act, op_a, op_b;
        logic signed [W:0] err;
        logic [W-1:0]    mag;
        logic            err_pos, err_neg;
        logic            cw_block, ccw_block;
        state_t          state_q, state_d;
        logic [CW-1:0]   cnt_q, cnt_d;
        logic [1:0]      cmd;
        logic            flt;

        assign r1  = (g == 0) ? bus.R_vertical_1 : bus.R_horizontal_1;
        assign r2  = (g == 0) ? bus.R_vertical_2 : bus.R_horizontal_2;
        assign tgt = (g == 0) ? bus.teta_manual  : bus.fi_manual;
        assign act = (g == 0) ? bus.teta_actual  : bus.fi_actual;

        assign op_a = bus.s ? tgt : r1;
        assign op_b = bus.s ? act : r2;

        // One extra bit of headroom makes the difference exact; |e| always fits in W bits.
        assign err     = $signed({1'b0, op_a}) - $signed({1'b0, op_b});
        assign err_neg = err[W];
        assign err_pos = !err[W] && (err != '0);
        assign mag     = err_neg ? W'(-err) : err[W-1:0];

`ifdef POS_LIMIT_EN
        assign cw_block  = (act >= POS_MAX);
        assign ccw_block = (act <= POS_MIN);
`else
        assign cw_block  = 1'b0;
        assign ccw_block = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (toggle) begin
                state_d = ST_DWELL;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (mag > DB_W) begin
                            if (err_pos && !cw_block) begin
                                state_d = ST_CW;
                                cnt_d   = '0;
                            end else if (err_neg && !ccw_block) begin
                                state_d = ST_CCW;
                                cnt_d   = '0;
                            end
                        end
                    end
                    ST_CW, ST_CCW: begin
                        // Timeout outranks the stop conditions.
                        if (cnt_q == MOVE_LAST) begin
                            state_d = ST_FAULT;
                        end else if ((mag <= HYST_W) ||
                                     ((state_q == ST_CW)  && (err_neg || cw_block)) ||
                                     ((state_q == ST_CCW) && (err_pos || ccw_block))) begin
                            state_d = ST_DWELL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_DWELL: begin
                        if (cnt_q == DWELL_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        state_d = ST_FAULT;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end

        always_comb begin
            cmd = 2'b00;
            flt = 1'b0;
            case (state_q)
                ST_CW:    cmd = 2'b01;
                ST_CCW:   cmd = 2'b11;
                ST_FAULT: flt = 1'b1;
                default:  cmd = 2'b00;
            endcase
        end
    end

    assign bus.s_out_teta = g_axis[0].cmd;
    assign bus.falla_teta = g_axis[0].flt;
    assign bus.s_out_fi   = g_axis[1].cmd;
    assign bus.falla_fi   = g_axis[1].flt;
endmodule

// File: tb/tb_control_movimiento_param.sv
// tb/tb_control_movimiento_param.sv - directed and randomized check of control_movimiento_param against a reference model
module tb_control_movimiento_param;
    localparam int W         = 16;
    localparam int DEADBAND  = 8;
    localparam int HYST      = 2;
    localparam int DWELL_CYC = 5;
    localparam int MAX_MOVE  = 16;
    localparam int POS_MIN   = 100;
    localparam int POS_MAX   = 600;

    localparam int P_IDLE  = 0;
    localparam int P_CW    = 1;
    localparam int P_CCW   = 2;
    localparam int P_DWELL = 3;
    localparam int P_FAULT = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int   ph    [2];
    int   left  [2];
    int   moved [2];
    logic m_sq;

    control_movimiento_param_if #(.W(W)) bus ();

    control_movimiento_param #(
        .W(W), .DEADBAND(DEADBAND), .HYST(HYST), .DWELL_CYC(DWELL_CYC),
        .MAX_MOVE(MAX_MOVE), .POS_MIN(16'(POS_MIN)), .POS_MAX(16'(POS_MAX))
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] axis_exp(input int ax);
        case (ph[ax])
            P_CW:    return 3'b010;
            P_CCW:   return 3'b110;
            P_FAULT: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [5:0] model_out();
        return {axis_exp(0), axis_exp(1)};
    endfunction

    function automatic logic [5:0] dut_out();
        return {bus.s_out_teta, bus.falla_teta, bus.s_out_fi, bus.falla_fi};
    endfunction

    task automatic model_axis(input int ax, input bit tog);
        int a, b, act, e, mag;
        bit cwb, ccwb;
        if (ax == 0) begin
            act = int'(bus.teta_actual);
            a   = bus.s ? int'(bus.teta_manual) : int'(bus.R_vertical_1);
            b   = bus.s ? act : int'(bus.R_vertical_2);
        end else begin
            act = int'(bus.fi_actual);
            a   = bus.s ? int'(bus.fi_manual) : int'(bus.R_horizontal_1);
            b   = bus.s ? act : int'(bus.R_horizontal_2);
        end
        e   = a - b;
        mag = (e < 0) ? -e : e;
`ifdef POS_LIMIT_EN
        cwb  = (act >= POS_MAX);
        ccwb = (act <= POS_MIN);
`else
        cwb  = 1'b0;
        ccwb = 1'b0;
`endif
        if (tog) begin
            ph[ax]   = P_DWELL;
            left[ax] = DWELL_CYC;
            return;
        end
        case (ph[ax])
            P_IDLE: begin
                if (mag > DEADBAND && e > 0 && !cwb) begin
                    ph[ax] = P_CW;  moved[ax] = 1;
                end else if (mag > DEADBAND && e < 0 && !ccwb) begin
                    ph[ax] = P_CCW; moved[ax] = 1;
                end
            end
            P_CW, P_CCW: begin
                if (moved[ax] == MAX_MOVE) begin
                    ph[ax] = P_FAULT;
                end else if (mag <= HYST ||
                             (ph[ax] == P_CW  && (e < 0 || cwb)) ||
                             (ph[ax] == P_CCW && (e > 0 || ccwb))) begin
                    ph[ax]   = P_DWELL;
                    left[ax] = DWELL_CYC;
                end else begin
                    moved[ax]++;
                end
            end
            P_DWELL: begin
                if (left[ax] == 1) ph[ax] = P_IDLE;
                else left[ax]--;
            end
            default: ph[ax] = P_FAULT;
        endcase
    endtask

    task automatic model_update();
        bit tog;
        if (rst) begin
            ph[0] = P_IDLE;
            ph[1] = P_IDLE;
            m_sq  = bus.s;
            return;
        end
        tog  = (bus.s != m_sq);
        m_sq = bus.s;
        model_axis(0, tog);
        model_axis(1, tog);
    endtask

    // Inputs are already set; predict the post-edge state, clock once, then compare.
    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check(tag, dut_out(), model_out());
    endtask

    task automatic steps(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic rand_inputs();
        if ($urandom_range(0, 5) == 0) bus.R_vertical_1   = 16'(960 + $urandom_range(0, 80));
        if ($urandom_range(0, 5) == 0) bus.R_vertical_2   = 16'(960 + $urandom_range(0, 80));
        if ($urandom_range(0, 5) == 0) bus.R_horizontal_1 = 16'(960 + $urandom_range(0, 80));
        if ($urandom_range(0, 5) == 0) bus.R_horizontal_2 = 16'(960 + $urandom_range(0, 80));
        if ($urandom_range(0, 5) == 0) bus.teta_manual    = 16'($urandom_range(50, 750));
        if ($urandom_range(0, 5) == 0) bus.teta_actual    = 16'($urandom_range(50, 750));
        if ($urandom_range(0, 5) == 0) bus.fi_manual      = 16'($urandom_range(50, 750));
        if ($urandom_range(0, 5) == 0) bus.fi_actual      = 16'($urandom_range(50, 750));
        if ($urandom_range(0, 59) == 0) bus.s = ~bus.s;
        rst = ($urandom_range(0, 249) == 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.s = 1'b0;
        bus.R_vertical_1 = '0;   bus.R_vertical_2 = '0;
        bus.R_horizontal_1 = '0; bus.R_horizontal_2 = '0;
        bus.teta_manual = '0;    bus.teta_actual = '0;
        bus.fi_manual = '0;      bus.fi_actual = '0;
        m_sq = 1'b0;
        step("reset");
        check("reset_const", dut_out(), 6'b000000);
        rst = 1'b0;

        // Automatic start, hysteresis stop, dwell back to idle.
        bus.R_vertical_1 = 16'd1000; bus.R_vertical_2 = 16'd990;
        bus.R_horizontal_1 = 16'd1000; bus.R_horizontal_2 = 16'd1000;
        step("auto_start");
        check("auto_cw_const", dut_out(), 6'b010000);
        bus.R_vertical_1 = 16'd992;
        step("hyst_stop");
        check("hyst_stop_const", dut_out(), 6'b000000);
        steps("dwell_idle", DWELL_CYC + 2);

        // Error exactly at the deadband never starts a move.
        bus.R_vertical_1 = 16'd998;    bus.R_vertical_2 = 16'd990;
        bus.R_horizontal_1 = 16'd1008; bus.R_horizontal_2 = 16'd1000;
        steps("deadband_edge", 20);
        check("deadband_const", dut_out(), 6'b000000);

        // Reversal passes through a full dwell.
        bus.R_horizontal_1 = 16'd1000;
        bus.R_vertical_1 = 16'd1010;
        step("rev_cw");
        bus.R_vertical_1 = 16'd970;
        step("rev_flip");
        steps("rev_dwell", DWELL_CYC - 1);
        check("rev_dwell_const", dut_out(), 6'b000000);
        step("rev_idle");
        step("rev_ccw");
        check("rev_ccw_const", dut_out(), 6'b110000);
        bus.R_vertical_1 = 16'd990;
        steps("rev_settle", DWELL_CYC + 3);

        // Timeout into fault, then a mode toggle clears it.
        bus.R_vertical_1 = 16'd1040;
        steps("timeout_move", MAX_MOVE);
        check("timeout_last_move", dut_out(), 6'b010000);
        step("timeout_fault");
        check("fault_const", dut_out(), 6'b001000);
        bus.s = 1'b1;
        step("toggle_clear");
        check("toggle_clear_const", dut_out(), 6'b000000);
        steps("manual_settle", DWELL_CYC + 3);

        // Manual move, toggle mid-move, reset mid-dwell.
        bus.teta_manual = 16'd500; bus.teta_actual = 16'd400;
        step("manual_cw");
        check("manual_cw_const", dut_out(), 6'b010000);
        bus.R_vertical_1 = 16'd990;
        bus.s = 1'b0;
        step("manual_toggle");
        check("manual_toggle_const", dut_out(), 6'b000000);
        steps("toggle_dwell", 2);
        rst = 1'b1;
        step("rst_dwell");
        check("rst_dwell_const", dut_out(), 6'b000000);
        rst = 1'b0;

        // Travel limit on fi.
        bus.teta_manual = 16'd400;
        bus.s = 1'b1;
        steps("limit_settle", DWELL_CYC + 3);
        bus.fi_manual = 16'd700; bus.fi_actual = 16'd600;
        step("limit_fi");
`ifdef POS_LIMIT_EN
        check("limit_fi_const", dut_out(), 6'b000000);
`else
        check("limit_fi_const", dut_out(), 6'b000010);
`endif

        for (int i = 0; i < 4000; i++) begin
            rand_inputs();
            step("random");
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
